// File: rtl/wlan_pll_pkg.sv
// WLAN PLL lock supervisor shared types and constants.
// State encoding, count widths and default timing.
package wlan_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUNNING,
    FAILED
  } pll_state_t;

  localparam int RELOCK_W = 8;
  localparam int RETRY_W  = 4;

  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT  = 40000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;
  localparam int DEF_LOSS_FILTER   = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/wlan_sync_bit.sv
// Two-flop synchronizer for a single status bit.
// Asynchronous clear forces both stages to 0.
module wlan_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back capture stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wlan_pll_lock_supervisor.sv
// WLAN PLL lock supervisor: reset, lock wait, qualify, run, retry.
// Optional unlock glitch filter: define WLAN_PLL_LOCK_FILTER_EN.
module wlan_pll_lock_supervisor
  import wlan_pll_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int LOSS_FILTER   = DEF_LOSS_FILTER
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                restart,
  output logic                pll_rst,
  output logic                sys_reset,
  output logic                clk_ready,
  output logic                fail,
`ifdef WLAN_PLL_LOCK_FILTER_EN
  output logic [RELOCK_W-1:0] glitch_count,
`endif
  output logic [RELOCK_W-1:0] relock_count,
  output logic [RETRY_W-1:0]  retry_count
);

  localparam int TMAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  if (RESET_CYCLES < 2 || MAX_RETRIES < 1 || MAX_RETRIES > 15 ||
      LOSS_FILTER < 1) begin : g_bad_param
    $error("wlan_pll_lock_supervisor: parameter out of range");
  end

  pll_state_t          state, nstate;
  logic [TW-1:0]       timer, timer_n;
  logic [RETRY_W-1:0]  retry_n;
  logic [RELOCK_W-1:0] relock_n;
  logic                locked_s;
  logic                loss;
  logic                attempt_fail;

  wlan_sync_bit u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

`ifdef WLAN_PLL_LOCK_FILTER_EN
  localparam int FW = (LOSS_FILTER > 2) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(LOSS_FILTER - 1);

  logic [FW-1:0]       filt, filt_n;
  logic [RELOCK_W-1:0] glitch_n;

  // Unlock persistence filter and glitch statistics
  always_comb begin
    filt_n   = '0;
    glitch_n = glitch_count;
    loss     = 1'b0;
    if (state == RUNNING && !restart) begin
      if (!locked_s) begin
        if (filt == FILT_LAST) loss = 1'b1;
        else filt_n = filt + FW'(1);
      end else if (filt != '0) begin
        if (glitch_count != '1) glitch_n = glitch_count + RELOCK_W'(1);
      end
    end
  end

  // Filter state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      filt         <= '0;
      glitch_count <= '0;
    end else begin
      filt         <= filt_n;
      glitch_count <= glitch_n;
    end
  end
`else
  // Any single unlocked cycle is a loss
  always_comb begin
    loss = !locked_s;
  end
`endif

  // Next state, timer and counters
  always_comb begin
    nstate       = state;
    timer_n      = timer + TW'(1);
    retry_n      = retry_count;
    relock_n     = relock_count;
    attempt_fail = 1'b0;
    unique case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) begin
          nstate  = WAIT_LOCK;
          timer_n = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          nstate  = STABLE;
          timer_n = '0;
        end else if (timer == LOCK_LAST) begin
          attempt_fail = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (timer == STB_LAST) begin
          nstate  = RUNNING;
          timer_n = '0;
          retry_n = '0;
        end
      end
      RUNNING: begin
        timer_n = '0;
        if (loss) begin
          nstate = RESET_PLL;
          if (relock_count != '1) relock_n = relock_count + RELOCK_W'(1);
        end
      end
      FAILED: begin
        timer_n = '0;
      end
      default: begin
        nstate  = RESET_PLL;
        timer_n = '0;
      end
    endcase
    if (attempt_fail) begin
      timer_n = '0;
      retry_n = retry_count + RETRY_W'(1);
      nstate  = (retry_n == RETRY_MAX) ? FAILED : RESET_PLL;
    end
    if (restart) begin
      nstate   = RESET_PLL;
      timer_n  = '0;
      retry_n  = '0;
      relock_n = relock_count;
    end
  end

  // State, counters and outputs registered from next state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state        <= RESET_PLL;
      timer        <= '0;
      retry_count  <= '0;
      relock_count <= '0;
      pll_rst      <= 1'b1;
      sys_reset    <= 1'b1;
      clk_ready    <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= nstate;
      timer        <= timer_n;
      retry_count  <= retry_n;
      relock_count <= relock_n;
      pll_rst      <= (nstate == RESET_PLL) || (nstate == FAILED);
      sys_reset    <= (nstate != RUNNING);
      clk_ready    <= (nstate == RUNNING);
      fail         <= (nstate == FAILED);
    end
  end

endmodule

// File: tb/tb_wlan_pll_lock_supervisor.sv
// Directed bench for wlan_pll_lock_supervisor.
// Cycle k is sampled at the k-th falling edge after rst release.
module tb_wlan_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_reset, clk_ready, fail;
  logic [7:0] relock_count;
  logic [3:0] retry_count;
`ifdef WLAN_PLL_LOCK_FILTER_EN
  logic [7:0] glitch_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int c0;
  int relock_exp;

  always #5 refclk = ~refclk;

  wlan_pll_lock_supervisor #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (3),
    .LOSS_FILTER   (8)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .sys_reset    (sys_reset),
    .clk_ready    (clk_ready),
    .fail         (fail),
`ifdef WLAN_PLL_LOCK_FILTER_EN
    .glitch_count (glitch_count),
`endif
    .relock_count (relock_count),
    .retry_count  (retry_count)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step_to(input int k);
    while (cyc < k) begin
      @(negedge refclk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst = 1'b1;
    pll_locked = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
`ifdef WLAN_PLL_LOCK_FILTER_EN
    relock_exp = 1;
`else
    relock_exp = 2;
`endif

    // Lock, run, glitch, then permanent loss into FAILED
    do_reset();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_reset", sys_reset, 1);
    chk("rst_clk_ready", clk_ready, 0);
    chk("rst_fail", fail, 0);
    chk("rst_relock", relock_count, 0);
    chk("rst_retry", retry_count, 0);
    step_to(3);  chk("a_pll_rst_3", pll_rst, 1);
    step_to(4);  chk("a_pll_rst_4", pll_rst, 0);
    step_to(10); pll_locked = 1'b1;
    step_to(20); chk("a_ready_20", clk_ready, 0);
    step_to(21);
    chk("a_ready_21", clk_ready, 1);
    chk("a_sysrst_21", sys_reset, 0);
    chk("a_retry_21", retry_count, 0);
    step_to(25); pll_locked = 1'b0;
    step_to(26); pll_locked = 1'b1;
    step_to(27); chk("g_ready_27", clk_ready, 1);
    step_to(28);
`ifdef WLAN_PLL_LOCK_FILTER_EN
    chk("g_ready_28", clk_ready, 1);
    step_to(30);
    chk("g_ready_30", clk_ready, 1);
    chk("g_glitch_30", glitch_count, 1);
    chk("g_relock_30", relock_count, 0);
`else
    chk("g_ready_28", clk_ready, 0);
    chk("g_sysrst_28", sys_reset, 1);
    chk("g_relock_28", relock_count, 1);
`endif
    step_to(40); pll_locked = 1'b0;
    c0 = cyc;
    while (fail !== 1'b1 && cyc < c0 + 300) step_to(cyc + 1);
    chk("f_fail", fail, 1);
    chk("f_retry", retry_count, 3);
    chk("f_pll_rst", pll_rst, 1);
    chk("f_ready", clk_ready, 0);
    chk("f_relock", relock_count, relock_exp);

    // Restart out of FAILED
    c0 = cyc + 2;
    step_to(c0);     restart = 1'b1;
    step_to(c0 + 1); restart = 1'b0;
    chk("r_fail", fail, 0);
    chk("r_retry", retry_count, 0);
    chk("r_relock", relock_count, relock_exp);
    chk("r_pll_rst_1", pll_rst, 1);
    step_to(c0 + 4); chk("r_pll_rst_4", pll_rst, 1);
    step_to(c0 + 5); chk("r_pll_rst_5", pll_rst, 0);

    // Timeouts with PLL never locking
    do_reset();
    step_to(3);  chk("t_pll_rst_3", pll_rst, 1);
    step_to(4);  chk("t_pll_rst_4", pll_rst, 0);
    step_to(23); chk("t_retry_23", retry_count, 0);
    step_to(24);
    chk("t_retry_24", retry_count, 1);
    chk("t_pll_rst_24", pll_rst, 1);
    step_to(27); chk("t_pll_rst_27", pll_rst, 1);
    step_to(28); chk("t_pll_rst_28", pll_rst, 0);
    step_to(48); chk("t_retry_48", retry_count, 2);
    step_to(71);
    chk("t_fail_71", fail, 0);
    chk("t_retry_71", retry_count, 2);
    step_to(72);
    chk("t_fail_72", fail, 1);
    chk("t_retry_72", retry_count, 3);
    chk("t_pll_rst_72", pll_rst, 1);
    chk("t_sysrst_72", sys_reset, 1);

    // Unlock on the STABLE terminal cycle
    do_reset();
    step_to(10); pll_locked = 1'b1;
    step_to(18); pll_locked = 1'b0;
    step_to(19); pll_locked = 1'b1;
    step_to(21);
    chk("s_retry_21", retry_count, 1);
    chk("s_ready_21", clk_ready, 0);
    chk("s_pll_rst_21", pll_rst, 1);
    step_to(33); chk("s_ready_33", clk_ready, 0);
    step_to(34);
    chk("s_ready_34", clk_ready, 1);
    chk("s_retry_34", retry_count, 0);

    // Asynchronous reset while in STABLE
    do_reset();
    step_to(10); pll_locked = 1'b1;
    step_to(15);
    chk("x_pll_rst_15", pll_rst, 0);
    rst = 1'b1;
    #1;
    chk("x_pll_rst", pll_rst, 1);
    chk("x_sys_reset", sys_reset, 1);
    chk("x_clk_ready", clk_ready, 0);
    chk("x_fail", fail, 0);
    chk("x_retry", retry_count, 0);
    @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
    step_to(4);  chk("x_pll_rst_4", pll_rst, 0);
    step_to(12); chk("x_ready_12", clk_ready, 0);
    step_to(13);
    chk("x_ready_13", clk_ready, 1);
    chk("x_sysrst_13", sys_reset, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
